// File: rtl/decode_pkg.sv
// Shared LoongArch decode definitions: functional-unit bits, exception codes,
// field widths, buffer entry/decode records and the buffer RUN/HALT state.
package decode_pkg;
   localparam int FU_W  = 7;
   localparam int UOP_W = 6;
   localparam int REG_W = 5;
   localparam int EXC_W = 5;

   localparam int FU_ALU = 0;
   localparam int FU_MDU = 1;
   localparam int FU_BR  = 2;
   localparam int FU_LSU = 3;
   localparam int FU_CSR = 4;

   localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
   localparam logic [EXC_W-1:0] EXC_ERTN = 5'd2;
   localparam logic [EXC_W-1:0] EXC_INE  = 5'd4;
   localparam logic [EXC_W-1:0] EXC_SYS  = 5'd5;
   localparam logic [EXC_W-1:0] EXC_BRK  = 5'd6;

   localparam logic [UOP_W-1:0] UOP_ADD   = 6'd0;
   localparam logic [UOP_W-1:0] UOP_SUB   = 6'd1;
   localparam logic [UOP_W-1:0] UOP_AND   = 6'd2;
   localparam logic [UOP_W-1:0] UOP_OR    = 6'd3;
   localparam logic [UOP_W-1:0] UOP_XOR   = 6'd4;
   localparam logic [UOP_W-1:0] UOP_LUI   = 6'd5;
   localparam logic [UOP_W-1:0] UOP_MUL   = 6'd6;
   localparam logic [UOP_W-1:0] UOP_BEQ   = 6'd7;
   localparam logic [UOP_W-1:0] UOP_CSRRD = 6'd8;
   localparam logic [UOP_W-1:0] UOP_CSRWR = 6'd9;
   localparam logic [UOP_W-1:0] UOP_CSRXC = 6'd10;
   localparam logic [UOP_W-1:0] UOP_LD    = 6'd11;
   localparam logic [UOP_W-1:0] UOP_ST    = 6'd12;
   localparam logic [UOP_W-1:0] UOP_SYS   = 6'd13;
   localparam logic [UOP_W-1:0] UOP_BRK   = 6'd14;
   localparam logic [UOP_W-1:0] UOP_ERTN  = 6'd15;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} buf_state_e;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      inst;
      logic [EXC_W-1:0] exc;
   } entry_t;

   typedef struct packed {
      logic [FU_W-1:0]  futype;
      logic [UOP_W-1:0] uop;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             rs1_en;
      logic             rs2_en;
      logic             rd_en;
      logic [31:0]      imm;
      logic [EXC_W-1:0] exc;
   } dec_t;
endpackage

// File: rtl/decode_loongarch.sv
// Single-instruction LoongArch decoder, purely combinational (zero latency, no handshake).
// A nonzero fetch exception overrides any exception the instruction itself raises.
module decode_loongarch
   import decode_pkg::*;
(
   input  logic [31:0]      inst_i,
   input  logic [EXC_W-1:0] fetch_exc_i,
   output dec_t             dec_o
);
   logic [REG_W-1:0] rd, rj, rk;
   logic [EXC_W-1:0] dec_exc;

   assign rd = inst_i[4:0];
   assign rj = inst_i[9:5];
   assign rk = inst_i[14:10];

   always_comb begin
      dec_o     = '0;
      dec_o.rs1 = rj;
      dec_o.rs2 = rk;
      dec_o.rd  = rd;
      dec_exc   = EXC_NONE;
      case (inst_i[31:15])
         17'h00020, 17'h00022, 17'h00029, 17'h0002A, 17'h0002B: begin
            dec_o.futype[FU_ALU] = 1'b1;
            {dec_o.rs1_en, dec_o.rs2_en, dec_o.rd_en} = 3'b111;
            case (inst_i[19:15])
               5'h00:   dec_o.uop = UOP_ADD;
               5'h02:   dec_o.uop = UOP_SUB;
               5'h09:   dec_o.uop = UOP_AND;
               5'h0A:   dec_o.uop = UOP_OR;
               default: dec_o.uop = UOP_XOR;
            endcase
         end
         17'h00038: begin
            dec_o.futype[FU_MDU] = 1'b1;
            dec_o.uop = UOP_MUL;
            {dec_o.rs1_en, dec_o.rs2_en, dec_o.rd_en} = 3'b111;
         end
         17'h00054: begin
            dec_o.futype[FU_CSR] = 1'b1;
            dec_o.uop = UOP_BRK;
            dec_exc   = EXC_BRK;
         end
         17'h00056: begin
            dec_o.futype[FU_CSR] = 1'b1;
            dec_o.uop = UOP_SYS;
            dec_exc   = EXC_SYS;
         end
         default: begin
            if (inst_i[31:22] == 10'h00A || inst_i[31:22] == 10'h0A2) begin
               dec_o.futype[(inst_i[31:22] == 10'h00A) ? FU_ALU : FU_LSU] = 1'b1;
               dec_o.uop    = (inst_i[31:22] == 10'h00A) ? UOP_ADD : UOP_LD;
               dec_o.rs1_en = 1'b1;
               dec_o.rd_en  = 1'b1;
               dec_o.imm    = {{20{inst_i[21]}}, inst_i[21:10]};
            end else if (inst_i[31:22] == 10'h0A6) begin
               // store data register sits in the rd field
               dec_o.futype[FU_LSU] = 1'b1;
               dec_o.uop    = UOP_ST;
               dec_o.rs2    = rd;
               dec_o.rs1_en = 1'b1;
               dec_o.rs2_en = 1'b1;
               dec_o.imm    = {{20{inst_i[21]}}, inst_i[21:10]};
            end else if (inst_i[31:25] == 7'h0A) begin
               dec_o.futype[FU_ALU] = 1'b1;
               dec_o.uop   = UOP_LUI;
               dec_o.rd_en = 1'b1;
               dec_o.imm   = {inst_i[24:5], 12'h000};
            end else if (inst_i[31:26] == 6'h16) begin
               dec_o.futype[FU_BR] = 1'b1;
               dec_o.uop    = UOP_BEQ;
               dec_o.rs2    = rd;
               dec_o.rs1_en = 1'b1;
               dec_o.rs2_en = 1'b1;
               dec_o.imm    = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
            end else if (inst_i[31:24] == 8'h04) begin
               dec_o.futype[FU_CSR] = 1'b1;
               dec_o.rd_en = 1'b1;
               dec_o.rs2   = rd;
               dec_o.imm   = {18'h0, inst_i[23:10]};
               if (rj == 5'd0) begin
                  dec_o.uop = UOP_CSRRD;
               end else if (rj == 5'd1) begin
                  dec_o.uop    = UOP_CSRWR;
                  dec_o.rs2_en = 1'b1;
               end else begin
                  dec_o.uop    = UOP_CSRXC;
                  dec_o.rs1_en = 1'b1;
                  dec_o.rs2_en = 1'b1;
               end
            end else if (inst_i == 32'h06483800) begin
               dec_o.futype[FU_CSR] = 1'b1;
               dec_o.uop = UOP_ERTN;
               dec_exc   = EXC_ERTN;
            end else begin
               dec_exc = EXC_INE;
            end
         end
      endcase
      dec_o.exc = (fetch_exc_i != EXC_NONE) ? fetch_exc_i : dec_exc;
   end
endmodule

// File: rtl/decode_buffer_loongarch.sv
// Flop-based instruction buffer feeding WIDTH decode lanes; entries reach lane 0 one cycle after enqueue.
// in_ready only when a full packet fits (registered state); out_ready takes every valid lane at once.
module decode_buffer_loongarch
   import decode_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_mask,
   input  logic [32*WIDTH-1:0]   in_inst,
   input  logic [32*WIDTH-1:0]   in_pc,
   input  logic [EXC_W*WIDTH-1:0] in_exc,
   output logic [WIDTH-1:0]      out_valid,
   input  logic                  out_ready,
   output logic [32*WIDTH-1:0]   out_pc,
   output logic [32*WIDTH-1:0]   out_inst,
   output logic [FU_W*WIDTH-1:0] out_futype,
   output logic [UOP_W*WIDTH-1:0] out_uop,
   output logic [REG_W*WIDTH-1:0] out_rs1,
   output logic [REG_W*WIDTH-1:0] out_rs2,
   output logic [REG_W*WIDTH-1:0] out_rd,
   output logic [WIDTH-1:0]      out_rs1_en,
   output logic [WIDTH-1:0]      out_rs2_en,
   output logic [WIDTH-1:0]      out_rd_en,
   output logic [32*WIDTH-1:0]   out_imm,
   output logic [EXC_W*WIDTH-1:0] out_exc
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   typedef logic [PW-1:0] ptr_t;

   entry_t     mem_q [DEPTH];
   ptr_t       head_q, head_d, tail_q, tail_d;
   ptr_t       count, enq_n, deq_n;
   ptr_t       slot_off [WIDTH];
   logic [AW-1:0] wr_idx [WIDTH];
   buf_state_e state_q, state_d;
   logic       enq, deq;
   entry_t     lane_ent [WIDTH];
   dec_t       lane_dec [WIDTH];
   logic [WIDTH-1:0] lane_ser;

   assign count    = tail_q - head_q;
   assign in_ready = ((ptr_t'(DEPTH) - count) >= ptr_t'(WIDTH)) && !flush;
   assign enq      = in_valid && in_ready;
   assign deq      = out_ready && out_valid[0] && !flush;

   // Masked-in slots pack densely from tail in ascending slot order
   always_comb begin
      enq_n = '0;
      for (int k = 0; k < WIDTH; k++) begin
         slot_off[k] = enq_n;
         wr_idx[k]   = tail_q[AW-1:0] + enq_n[AW-1:0];
         enq_n       = enq_n + ptr_t'(in_mask[k]);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < WIDTH; k++) begin
         if (enq && in_mask[k]) begin
            mem_q[wr_idx[k]] <= '{in_pc[32*k +: 32], in_inst[32*k +: 32], in_exc[EXC_W*k +: EXC_W]};
         end
      end
   end

   for (genvar k = 0; k < WIDTH; k++) begin : g_lane
      logic [AW-1:0] rd_idx;
      assign rd_idx      = head_q[AW-1:0] + AW'(k);
      assign lane_ent[k] = mem_q[rd_idx];
      decode_loongarch u_dec (
         .inst_i      (lane_ent[k].inst),
         .fetch_exc_i (lane_ent[k].exc),
         .dec_o       (lane_dec[k])
      );
      assign lane_ser[k] = lane_dec[k].futype[FU_CSR] || (lane_dec[k].exc != EXC_NONE);
   end

   // A serialising head entry issues alone; one further back stops the group before it
   always_comb begin
      out_valid    = '0;
      out_valid[0] = (count != '0) && (state_q == ST_RUN);
      for (int k = 1; k < WIDTH; k++) begin
         out_valid[k] = out_valid[k-1] && (count > ptr_t'(k)) && !lane_ser[k] && !lane_ser[0];
      end
      deq_n = '0;
      for (int k = 0; k < WIDTH; k++) deq_n = deq_n + ptr_t'(out_valid[k]);
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      state_d = state_q;
      if (flush) begin
         head_d  = tail_q;
         state_d = ST_RUN;
      end else begin
         if (enq) tail_d = tail_q + enq_n;
         if (deq) head_d = head_q + deq_n;
         if (state_q == ST_RUN && deq && lane_dec[0].exc != EXC_NONE) state_d = ST_HALT;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         state_q <= ST_RUN;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      out_pc = '0; out_inst = '0; out_futype = '0; out_uop = '0;
      out_rs1 = '0; out_rs2 = '0; out_rd = '0; out_imm = '0; out_exc = '0;
      out_rs1_en = '0; out_rs2_en = '0; out_rd_en = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (out_valid[k]) begin
            out_pc[32*k +: 32]          = lane_ent[k].pc;
            out_inst[32*k +: 32]        = lane_ent[k].inst;
            out_futype[FU_W*k +: FU_W]  = lane_dec[k].futype;
            out_uop[UOP_W*k +: UOP_W]   = lane_dec[k].uop;
            out_rs1[REG_W*k +: REG_W]   = lane_dec[k].rs1;
            out_rs2[REG_W*k +: REG_W]   = lane_dec[k].rs2;
            out_rd[REG_W*k +: REG_W]    = lane_dec[k].rd;
            out_rs1_en[k]               = lane_dec[k].rs1_en;
            out_rs2_en[k]               = lane_dec[k].rs2_en;
            out_rd_en[k]                = lane_dec[k].rd_en;
            out_imm[32*k +: 32]         = lane_dec[k].imm;
            out_exc[EXC_W*k +: EXC_W]   = lane_dec[k].exc;
         end
      end
   end
endmodule
